// File: rtl/qwic51_fetch_pkg.sv
// Shared QWIC51 core definitions: widths, opcode constants, fetch FSM encoding,
// instruction length decode and the reference ROM image.
package qwic51_fetch_pkg;

    localparam int CPU_ROM_ADDWID = 8;
    localparam int CPU_DATA_WIDTH = 8;

    localparam logic [7:0] NOP_CTRL   = 8'h00;
    localparam logic [7:0] RESET_CTRL = 8'h01;
    localparam logic [7:0] AJMP_CTRL  = 8'h02;
    localparam logic [7:0] LCALL_CTRL = 8'h12;
    localparam logic [7:0] RET_CTRL   = 8'h22;
    localparam logic [7:0] MOV_CTRL   = 8'h75;
    localparam logic [7:0] CLR_CTRL   = 8'hC0;
    localparam logic [7:0] DJNZ_CTRL  = 8'hD5;
    localparam logic [7:0] SETB_CTRL  = 8'hE0;

    localparam logic [7:0] R0 = 8'h00;
    localparam logic [7:0] P0 = 8'h80;

    localparam logic [2:0] ST_FILL = 3'd0;
    localparam logic [2:0] ST_OPC  = 3'd1;
    localparam logic [2:0] ST_OP1  = 3'd2;
    localparam logic [2:0] ST_OP2  = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    typedef struct packed {
        logic [CPU_ROM_ADDWID-1:0] pc;
        logic [7:0]                opcode;
        logic [7:0]                opnd1;
        logic [7:0]                opnd2;
        logic [1:0]                len;
    } fet_instr_t;

    // CLR and SETB carry a bit index in the low nibble, so only the high nibble selects them.
    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic [1:0] len;
        len = 2'd1;
        if (op == AJMP_CTRL || op == LCALL_CTRL)
            len = 2'd2;
        else if (op[7:4] == CLR_CTRL[7:4] || op[7:4] == SETB_CTRL[7:4])
            len = 2'd2;
        else if (op == MOV_CTRL || op == DJNZ_CTRL)
            len = 2'd3;
        return len;
    endfunction

    function automatic logic [CPU_DATA_WIDTH-1:0] qwic51_rom_byte(input logic [CPU_ROM_ADDWID-1:0] a);
        logic [CPU_DATA_WIDTH-1:0] d;
        case (a)
            8'h00:   d = RESET_CTRL;
            8'h01:   d = AJMP_CTRL;
            8'h02:   d = 8'h50;
            8'h03:   d = NOP_CTRL;
            8'h04:   d = CLR_CTRL + 8'd3;
            8'h05:   d = 8'h21;
            8'h06:   d = DJNZ_CTRL;
            8'h07:   d = 8'h07;
            8'h08:   d = 8'hFE;
            8'h09:   d = RET_CTRL;
            8'h0A:   d = 8'h44;
            8'h0B:   d = LCALL_CTRL;
            8'h0C:   d = 8'h30;
            8'h56:   d = SETB_CTRL;
            8'h57:   d = P0;
            8'h58:   d = RET_CTRL;
            8'h60:   d = MOV_CTRL;
            8'h61:   d = R0;
            8'h62:   d = 8'd240;
            8'h63:   d = 8'h44;
            8'h64:   d = LCALL_CTRL;
            8'h65:   d = 8'h33;
            8'h66:   d = RET_CTRL;
            default: d = NOP_CTRL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/qwic51_rom.sv
// Instruction ROM model with one cycle of read latency, matching the fetch timing.
module qwic51_rom
    import qwic51_fetch_pkg::*;
(
    input  logic                      CPU_CLK,
    input  logic [CPU_ROM_ADDWID-1:0] CPU_PC_ADDR,
    output logic [CPU_DATA_WIDTH-1:0] CPU_IR_REG
);

    always_ff @(posedge CPU_CLK) begin
        CPU_IR_REG <= qwic51_rom_byte(CPU_PC_ADDR);
    end

endmodule

// File: rtl/qwic51_fetch.sv
// QWIC51 instruction fetch: walks the ROM byte by byte, assembles 1..3 byte
// instructions and hands them to decode; execute can redirect at any time.
module qwic51_fetch
    import qwic51_fetch_pkg::*;
(
    input  logic                      CPU_CLK,
    input  logic                      CPU_RST_N,
    output logic [CPU_ROM_ADDWID-1:0] CPU_PC_ADDR,
    input  logic [CPU_DATA_WIDTH-1:0] CPU_IR_REG,
    output logic                      FET_VALID,
    input  logic                      FET_READY,
    output logic [7:0]                FET_OPCODE,
    output logic [7:0]                FET_OPND1,
    output logic [7:0]                FET_OPND2,
    output logic [1:0]                FET_LEN,
    output logic [CPU_ROM_ADDWID-1:0] FET_PC,
    input  logic                      BR_VALID,
    input  logic [CPU_ROM_ADDWID-1:0] BR_TARGET,
    output logic [2:0]                FET_STATE
);

    // Handshake: an instruction transfers on a rising edge where FET_VALID and
    // FET_READY are both 1 and BR_VALID is 0; while FET_VALID is 1 and no transfer
    // happens, every FET_* output and CPU_PC_ADDR stays unchanged.

    logic [2:0]                state_r;
    logic [2:0]                state_nx;
    logic [CPU_ROM_ADDWID-1:0] addr_r;
    logic [CPU_ROM_ADDWID-1:0] addr_nx;
    fet_instr_t                instr_r;
    fet_instr_t                instr_nx;
    logic [1:0]                len_dec;

    assign len_dec = op_len(CPU_IR_REG);

    // addr_r always runs one byte ahead of the byte sitting on CPU_IR_REG, so the
    // transfer out of HOLD must also advance it to keep that relation for the next opcode.
    always_comb begin
        state_nx = state_r;
        addr_nx  = addr_r;
        instr_nx = instr_r;
        if (BR_VALID) begin
            addr_nx  = BR_TARGET;
            state_nx = ST_FILL;
        end else begin
            case (state_r)
                ST_FILL: begin
                    addr_nx  = addr_r + 1'b1;
                    state_nx = ST_OPC;
                end
                ST_OPC: begin
                    instr_nx.opcode = CPU_IR_REG;
                    instr_nx.pc     = addr_r - 1'b1;
                    instr_nx.opnd1  = 8'h00;
                    instr_nx.opnd2  = 8'h00;
                    instr_nx.len    = len_dec;
                    if (len_dec == 2'd1) begin
                        state_nx = ST_HOLD;
                    end else begin
                        addr_nx  = addr_r + 1'b1;
                        state_nx = ST_OP1;
                    end
                end
                ST_OP1: begin
                    instr_nx.opnd1 = CPU_IR_REG;
                    if (instr_r.len == 2'd3) begin
                        addr_nx  = addr_r + 1'b1;
                        state_nx = ST_OP2;
                    end else begin
                        state_nx = ST_HOLD;
                    end
                end
                ST_OP2: begin
                    instr_nx.opnd2 = CPU_IR_REG;
                    state_nx       = ST_HOLD;
                end
                ST_HOLD: begin
                    if (FET_READY) begin
                        addr_nx  = addr_r + 1'b1;
                        state_nx = ST_OPC;
                    end
                end
                default: begin
                    state_nx = ST_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state_r <= ST_FILL;
            addr_r  <= '0;
            instr_r <= '0;
        end else begin
            state_r <= state_nx;
            addr_r  <= addr_nx;
            instr_r <= instr_nx;
        end
    end

    assign CPU_PC_ADDR = addr_r;
    assign FET_VALID   = (state_r == ST_HOLD);
    assign FET_OPCODE  = instr_r.opcode;
    assign FET_OPND1   = instr_r.opnd1;
    assign FET_OPND2   = instr_r.opnd2;
    assign FET_LEN     = instr_r.len;
    assign FET_PC      = instr_r.pc;
    assign FET_STATE   = state_r;

endmodule

// File: tb/tb_qwic51_fetch.sv
// Self-checking bench for qwic51_fetch: reference ROM plus a patchable ROM,
// scoreboard of expected instructions popped on every decode transfer.
module tb_qwic51_fetch;
    import qwic51_fetch_pkg::*;

    localparam int EW = 34;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pc_addr;
    logic [7:0] ir;
    logic [7:0] rom_q;
    logic [7:0] patch_q;
    logic       fet_valid;
    logic       fet_ready = 1'b0;
    logic [7:0] fet_opcode;
    logic [7:0] fet_opnd1;
    logic [7:0] fet_opnd2;
    logic [1:0] fet_len;
    logic [7:0] fet_pc;
    logic       br_valid = 1'b0;
    logic [7:0] br_target = 8'h00;
    logic [2:0] fet_state;

    logic       use_patch = 1'b0;
    logic [7:0] patch_mem [0:255];

    logic [EW-1:0] exp_q[$];
    int            xfer_cyc[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            xfer_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    qwic51_rom u_rom (
        .CPU_CLK     (clk),
        .CPU_PC_ADDR (pc_addr),
        .CPU_IR_REG  (rom_q)
    );

    always @(posedge clk) patch_q <= patch_mem[pc_addr];
    assign ir = use_patch ? patch_q : rom_q;

    qwic51_fetch dut (
        .CPU_CLK     (clk),
        .CPU_RST_N   (rst_n),
        .CPU_PC_ADDR (pc_addr),
        .CPU_IR_REG  (ir),
        .FET_VALID   (fet_valid),
        .FET_READY   (fet_ready),
        .FET_OPCODE  (fet_opcode),
        .FET_OPND1   (fet_opnd1),
        .FET_OPND2   (fet_opnd2),
        .FET_LEN     (fet_len),
        .FET_PC      (fet_pc),
        .BR_VALID    (br_valid),
        .BR_TARGET   (br_target),
        .FET_STATE   (fet_state)
    );

    function automatic logic [7:0] ref_byte(input logic [7:0] a);
        return use_patch ? patch_mem[a] : qwic51_rom_byte(a);
    endfunction

    function automatic logic [1:0] ref_len(input logic [7:0] op);
        if (op == AJMP_CTRL || op == LCALL_CTRL) return 2'd2;
        if (op >= CLR_CTRL && op <= CLR_CTRL + 8'd15) return 2'd2;
        if (op >= SETB_CTRL && op <= SETB_CTRL + 8'd15) return 2'd2;
        if (op == MOV_CTRL || op == DJNZ_CTRL) return 2'd3;
        return 2'd1;
    endfunction

    function automatic logic [EW-1:0] ent(input logic [7:0] pc, input logic [7:0] op,
                                          input logic [7:0] o1, input logic [7:0] o2,
                                          input logic [1:0] len);
        return {pc, op, o1, o2, len};
    endfunction

    // Scoreboard consumer: every accepted instruction must match the queue head.
    always @(negedge clk) begin
        logic [EW-1:0] got;
        logic [EW-1:0] e;
        if (rst_n && fet_valid && fet_ready && !br_valid) begin
            xfer_cnt++;
            xfer_cyc.push_back(cyc);
            total++;
            got = {fet_pc, fet_opcode, fet_opnd1, fet_opnd2, fet_len};
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL xfer_unexpected got pc=%h op=%h required no transfer", fet_pc, fet_opcode);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL xfer got pc=%h op=%h o1=%h o2=%h len=%0d required pc=%h op=%h o1=%h o2=%h len=%0d",
                             got[33:26], got[25:18], got[17:10], got[9:2], got[1:0],
                             e[33:26], e[25:18], e[17:10], e[9:2], e[1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_walk(input logic [7:0] start, input int n, output int cyc_sum);
        logic [7:0] pc;
        logic [7:0] op;
        logic [7:0] o1;
        logic [7:0] o2;
        logic [1:0] len;
        pc = start;
        cyc_sum = 0;
        for (int i = 0; i < n; i++) begin
            op  = ref_byte(pc);
            len = ref_len(op);
            o1  = (len >= 2'd2) ? ref_byte(pc + 8'd1) : 8'h00;
            o2  = (len == 2'd3) ? ref_byte(pc + 8'd2) : 8'h00;
            exp_q.push_back(ent(pc, op, o1, o2, len));
            cyc_sum += int'(len) + 1;
            pc = pc + {6'd0, len};
        end
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        fet_ready = 1'b1;
        while (exp_q.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        fet_ready = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got left=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_valid(input int max_cyc);
        int n;
        n = 0;
        while (fet_valid !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        total++;
        if (fet_valid !== 1'b1) begin
            bad++;
            $display("FAIL wait_valid_timeout got valid=%b required 1", fet_valid);
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int max_cyc);
        int n;
        n = 0;
        while (fet_state !== st && n < max_cyc) begin
            tick();
            n++;
        end
        total++;
        if (fet_state !== st) begin
            bad++;
            $display("FAIL wait_state_timeout got state=%0d required %0d", fet_state, st);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fet_ready = 1'b0;
        br_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        total++; if (pc_addr !== 8'h00) begin bad++; $display("FAIL rst_pc_addr got %h required 00", pc_addr); end
        total++; if (fet_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b required 0", fet_valid); end
        total++; if (fet_opcode !== 8'h00) begin bad++; $display("FAIL rst_opcode got %h required 00", fet_opcode); end
        total++; if (fet_opnd1 !== 8'h00 || fet_opnd2 !== 8'h00) begin bad++; $display("FAIL rst_opnd got %h/%h required 00/00", fet_opnd1, fet_opnd2); end
        total++; if (fet_pc !== 8'h00) begin bad++; $display("FAIL rst_fet_pc got %h required 00", fet_pc); end
        total++; if (fet_len !== 2'd0) begin bad++; $display("FAIL rst_len got %0d required 0", fet_len); end
        total++; if (fet_state !== ST_FILL) begin bad++; $display("FAIL rst_state got %0d required %0d", fet_state, ST_FILL); end
    endtask

    task automatic test_first_fetch();
        int sum;
        int first_valid;
        xfer_cyc.delete();
        exp_q.push_back(ent(8'h00, RESET_CTRL, 8'h00, 8'h00, 2'd1));
        exp_q.push_back(ent(8'h01, AJMP_CTRL, 8'h50, 8'h00, 2'd2));
        push_walk(8'h03, 5, sum);
        fet_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        first_valid = 0;
        for (int c = 1; c <= 8 && first_valid == 0; c++) begin
            @(negedge clk);
            if (fet_valid === 1'b1) first_valid = c;
        end
        total++; if (first_valid != 3) begin bad++; $display("FAIL first_valid_cycle got %0d required 3", first_valid); end
        drain(60);
        total++;
        if (xfer_cyc.size() != 7) begin
            bad++; $display("FAIL stream_count got %0d required 7", xfer_cyc.size());
        end else if (xfer_cyc[6] - xfer_cyc[0] != 3 + sum) begin
            bad++; $display("FAIL throughput got %0d required %0d", xfer_cyc[6] - xfer_cyc[0], 3 + sum);
        end
    endtask

    task automatic test_redirect();
        int sum;
        wait_valid(10);
        br_valid = 1'b1;
        br_target = 8'h60;
        tick();
        br_valid = 1'b0;
        @(negedge clk);
        total++; if (fet_valid !== 1'b0) begin bad++; $display("FAIL br_valid_drop got %b required 0", fet_valid); end
        total++; if (fet_state !== ST_FILL) begin bad++; $display("FAIL br_state got %0d required %0d", fet_state, ST_FILL); end
        exp_q.push_back(ent(8'h60, MOV_CTRL, R0, 8'd240, 2'd3));
        push_walk(8'h63, 1, sum);
        tick();
        drain(40);
    endtask

    task automatic test_stall();
        logic [EW-1:0] snap;
        logic [7:0]    snap_addr;
        int            base;
        wait_valid(10);
        @(negedge clk);
        snap = {fet_pc, fet_opcode, fet_opnd1, fet_opnd2, fet_len};
        snap_addr = pc_addr;
        total++; if (snap !== ent(8'h64, LCALL_CTRL, 8'h33, 8'h00, 2'd2)) begin bad++; $display("FAIL stall_held got %h required %h", snap, ent(8'h64, LCALL_CTRL, 8'h33, 8'h00, 2'd2)); end
        total++; if (snap_addr !== 8'h66) begin bad++; $display("FAIL stall_addr got %h required 66", snap_addr); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({fet_pc, fet_opcode, fet_opnd1, fet_opnd2, fet_len} !== snap || pc_addr !== snap_addr || fet_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_stable cycle=%0d got %h addr=%h valid=%b required %h addr=%h valid=1",
                         i, {fet_pc, fet_opcode, fet_opnd1, fet_opnd2, fet_len}, pc_addr, fet_valid, snap, snap_addr);
            end
        end
        exp_q.push_back(ent(8'h64, LCALL_CTRL, 8'h33, 8'h00, 2'd2));
        tick();
        base = xfer_cnt;
        fet_ready = 1'b1;
        tick();
        fet_ready = 1'b0;
        repeat (4) tick();
        total++; if (xfer_cnt - base != 1) begin bad++; $display("FAIL stall_release_xfers got %0d required 1", xfer_cnt - base); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stall_pending got %0d required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_br_with_ready();
        int base;
        wait_valid(10);
        base = xfer_cnt;
        br_valid = 1'b1;
        br_target = 8'h56;
        fet_ready = 1'b1;
        tick();
        br_valid = 1'b0;
        fet_ready = 1'b0;
        @(negedge clk);
        total++; if (fet_valid !== 1'b0) begin bad++; $display("FAIL br_ready_valid got %b required 0", fet_valid); end
        total++; if (xfer_cnt != base) begin bad++; $display("FAIL br_ready_xfer got %0d required %0d", xfer_cnt, base); end
        exp_q.push_back(ent(8'h56, SETB_CTRL, P0, 8'h00, 2'd2));
        tick();
        drain(20);
        total++; if (xfer_cnt != base + 1) begin bad++; $display("FAIL br_ready_total got %0d required %0d", xfer_cnt, base + 1); end
    endtask

    task automatic test_br_partial();
        wait_valid(10);
        br_valid = 1'b1;
        br_target = 8'h60;
        tick();
        br_valid = 1'b0;
        wait_state(ST_OP1, 10);
        br_valid = 1'b1;
        br_target = 8'h06;
        tick();
        br_valid = 1'b0;
        wait_state(ST_OP2, 10);
        br_valid = 1'b1;
        br_target = 8'h04;
        tick();
        br_valid = 1'b0;
        exp_q.push_back(ent(8'h04, CLR_CTRL + 8'd3, 8'h21, 8'h00, 2'd2));
        drain(20);
    endtask

    task automatic test_reset_mid();
        br_valid = 1'b1;
        br_target = 8'h60;
        tick();
        br_valid = 1'b0;
        wait_state(ST_OP1, 10);
        #2;
        rst_n = 1'b0;
        br_valid = 1'b1;
        br_target = 8'h60;
        #1;
        total++; if (fet_state !== ST_FILL || pc_addr !== 8'h00) begin bad++; $display("FAIL rst_async got state=%0d addr=%h required %0d/00", fet_state, pc_addr, ST_FILL); end
        total++; if (fet_opcode !== 8'h00 || fet_pc !== 8'h00) begin bad++; $display("FAIL rst_async_fields got op=%h pc=%h required 00/00", fet_opcode, fet_pc); end
        repeat (2) tick();
        @(negedge clk);
        total++; if (pc_addr !== 8'h00 || fet_valid !== 1'b0) begin bad++; $display("FAIL rst_br_ignored got addr=%h valid=%b required 00/0", pc_addr, fet_valid); end
        tick();
        br_valid = 1'b0;
        tick();
        exp_q.push_back(ent(8'h00, RESET_CTRL, 8'h00, 8'h00, 2'd1));
        exp_q.push_back(ent(8'h01, AJMP_CTRL, 8'h50, 8'h00, 2'd2));
        rst_n = 1'b1;
        drain(30);
    endtask

    task automatic test_wrap();
        int sum;
        wait_valid(10);
        patch_mem[8'hFF] = AJMP_CTRL;
        patch_mem[8'h00] = 8'h12;
        use_patch = 1'b1;
        br_valid = 1'b1;
        br_target = 8'hFF;
        tick();
        br_valid = 1'b0;
        wait_state(ST_OPC, 10);
        total++; if (pc_addr !== 8'h00) begin bad++; $display("FAIL wrap_addr got %h required 00", pc_addr); end
        exp_q.push_back(ent(8'hFF, AJMP_CTRL, 8'h12, 8'h00, 2'd2));
        push_walk(8'h01, 1, sum);
        drain(20);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) patch_mem[i] = 8'h00;
        test_reset();
        test_first_fetch();
        test_redirect();
        test_stall();
        test_br_with_ready();
        test_br_partial();
        test_reset_mid();
        test_wrap();
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
